// File: rtl/decode_execute_stage_reg.sv
// rtl/decode_execute_stage_reg.sv - Decode to Execute pipeline register with valid, stall, flush and bubble counter
module decode_execute_stage_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 12,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stallE,
    input  logic                      flushE,
    input  logic                      validD,
    input  logic [CTRL_WIDTH-1:0]     ctrlD,
    input  logic [DATA_WIDTH-1:0]     rd1D,
    input  logic [DATA_WIDTH-1:0]     rd2D,
    input  logic [ADDR_WIDTH-1:0]     PCD,
    input  logic [ADDR_WIDTH-1:0]     PCPlus4D,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    output logic                      validE,
    output logic [CTRL_WIDTH-1:0]     ctrlE,
    output logic [DATA_WIDTH-1:0]     rd1E,
    output logic [DATA_WIDTH-1:0]     rd2E,
    output logic [ADDR_WIDTH-1:0]     PCE,
    output logic [ADDR_WIDTH-1:0]     PCPlus4E,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [CNT_WIDTH-1:0]      bubble_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                      valid_q,   valid_d;
    logic [CTRL_WIDTH-1:0]     ctrl_q,    ctrl_d;
    logic [DATA_WIDTH-1:0]     rd1_q,     rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q,     rd2_d;
    logic [ADDR_WIDTH-1:0]     pc_q,      pc_d;
    logic [ADDR_WIDTH-1:0]     pc_plus4_q, pc_plus4_d;
    logic [DATA_WIDTH-1:0]     imm_q,     imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,     rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,     rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,      rd_d;
    logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;
    logic                      bubble;

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        bubble       = 1'b0;

        if (flushE) begin
            valid_d    = 1'b0;
            ctrl_d     = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            pc_d       = '0;
            pc_plus4_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            bubble     = 1'b1;
        end else if (!stallE) begin
            // Data and PCs are captured even for a bubble; only the fields the
            // hazard/forwarding logic matches on are cleared.
            rd1_d      = rd1D;
            rd2_d      = rd2D;
            pc_d       = PCD;
            pc_plus4_d = PCPlus4D;
            imm_d      = ImmExtD;
            valid_d    = validD;
            ctrl_d     = validD ? ctrlD : '0;
            rs1_d      = validD ? Rs1D  : '0;
            rs2_d      = validD ? Rs2D  : '0;
            rd_d       = validD ? RdD   : '0;
            bubble     = !validD;
        end

        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign validE       = valid_q;
    assign ctrlE        = ctrl_q;
    assign rd1E         = rd1_q;
    assign rd2E         = rd2_q;
    assign PCE          = pc_q;
    assign PCPlus4E     = pc_plus4_q;
    assign ImmExtE      = imm_q;
    assign Rs1E         = rs1_q;
    assign Rs2E         = rs2_q;
    assign RdE          = rd_q;
    assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_decode_execute_stage_reg.sv
// tb/tb_decode_execute_stage_reg.sv - scoreboard bench for decode_execute_stage_reg
module tb_decode_execute_stage_reg;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 12;
    localparam int NW = 4;

    typedef struct {
        logic          rst;
        logic          stall;
        logic          flush;
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
    } in_t;

    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic [NW-1:0] cnt;
    } out_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stallE = 1'b0;
    logic          flushE = 1'b0;
    logic          validD = 1'b0;
    logic [CW-1:0] ctrlD = '0;
    logic [DW-1:0] rd1D = '0;
    logic [DW-1:0] rd2D = '0;
    logic [AW-1:0] PCD = '0;
    logic [AW-1:0] PCPlus4D = '0;
    logic [DW-1:0] ImmExtD = '0;
    logic [RW-1:0] Rs1D = '0;
    logic [RW-1:0] Rs2D = '0;
    logic [RW-1:0] RdD = '0;
    logic          validE;
    logic [CW-1:0] ctrlE;
    logic [DW-1:0] rd1E;
    logic [DW-1:0] rd2E;
    logic [AW-1:0] PCE;
    logic [AW-1:0] PCPlus4E;
    logic [DW-1:0] ImmExtE;
    logic [RW-1:0] Rs1E;
    logic [RW-1:0] Rs2E;
    logic [RW-1:0] RdE;
    logic [NW-1:0] bubble_count;

    decode_execute_stage_reg #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW),
        .CTRL_WIDTH(CW), .CNT_WIDTH(NW)
    ) dut (
        .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE), .validD(validD),
        .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .validE(validE), .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    out_t exp_q[$];
    out_t last_exp;
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    function automatic in_t mk_in(logic r, logic s, logic f, logic v, logic [CW-1:0] c,
                                  logic [DW-1:0] d1, logic [AW-1:0] pc,
                                  logic [RW-1:0] r1, logic [RW-1:0] r2, logic [RW-1:0] rd);
        in_t i;
        i.rst = r; i.stall = s; i.flush = f; i.valid = v; i.ctrl = c;
        i.rd1 = d1; i.rd2 = ~d1; i.imm = d1 ^ 32'h5A5A_0F0F;
        i.pc = pc; i.pc4 = pc + 32'd4;
        i.rs1 = r1; i.rs2 = r2; i.rd = rd;
        return i;
    endfunction

    function automatic out_t exp_zero(logic [NW-1:0] cnt);
        out_t e;
        e.valid = 1'b0; e.ctrl = '0; e.rd1 = '0; e.rd2 = '0; e.pc = '0; e.pc4 = '0;
        e.imm = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.cnt = cnt;
        return e;
    endfunction

    function automatic out_t exp_data(in_t i, logic v, logic [NW-1:0] cnt);
        out_t e;
        e.valid = v;
        e.ctrl  = v ? i.ctrl : '0;
        e.rs1   = v ? i.rs1  : '0;
        e.rs2   = v ? i.rs2  : '0;
        e.rd    = v ? i.rd   : '0;
        e.rd1 = i.rd1; e.rd2 = i.rd2; e.pc = i.pc; e.pc4 = i.pc4; e.imm = i.imm;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic apply(in_t i, out_t e);
        @(negedge clk);
        rst = i.rst; stallE = i.stall; flushE = i.flush; validD = i.valid;
        ctrlD = i.ctrl; rd1D = i.rd1; rd2D = i.rd2; PCD = i.pc; PCPlus4D = i.pc4;
        ImmExtD = i.imm; Rs1D = i.rs1; Rs2D = i.rs2; RdD = i.rd;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            checks++;
            if (validE !== e.valid || ctrlE !== e.ctrl || rd1E !== e.rd1 || rd2E !== e.rd2 ||
                PCE !== e.pc || PCPlus4E !== e.pc4 || ImmExtE !== e.imm || Rs1E !== e.rs1 ||
                Rs2E !== e.rs2 || RdE !== e.rd || bubble_count !== e.cnt) begin
                errors++;
                $display("FAIL vec%0d actual v=%b ctrl=%h rd1=%h rd2=%h pc=%h pc4=%h imm=%h rs=%0d/%0d rd=%0d cnt=%0d required v=%b ctrl=%h rd1=%h rd2=%h pc=%h pc4=%h imm=%h rs=%0d/%0d rd=%0d cnt=%0d",
                         vec_no, validE, ctrlE, rd1E, rd2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, bubble_count,
                         e.valid, e.ctrl, e.rd1, e.rd2, e.pc, e.pc4, e.imm, e.rs1, e.rs2, e.rd, e.cnt);
            end
            vec_no++;
        end
    end

    initial begin
        in_t i;
        int  c;

        // Reset with busy D inputs, including a pending stall and flush
        i = mk_in(1, 0, 0, 1, 12'h7E1, 32'hDEAD_BEEF, 32'h0000_1000, 5'd9, 5'd10, 5'd11);
        apply(i, exp_zero(0));
        i = mk_in(1, 1, 1, 1, 12'h0F0, 32'hCAFE_F00D, 32'h0000_2000, 5'd1, 5'd2, 5'd3);
        apply(i, exp_zero(0));

        i = mk_in(0, 0, 0, 1, 12'h3A5, 32'h1234_5678, 32'h0000_0100, 5'd1, 5'd2, 5'd5);
        apply(i, exp_data(i, 1, 0));

        // Back-to-back valid instructions
        for (int k = 0; k < 4; k++) begin
            i = mk_in(0, 0, 0, 1, 12'h100 + 12'(k), 32'h0101_0000 * (k + 1),
                      32'(4 * k), 5'(k + 3), 5'(k + 7), 5'(k + 20));
            apply(i, exp_data(i, 1, 0));
        end

        // Stall holds the 0x20 instruction; release loads the live D inputs
        i = mk_in(0, 0, 0, 1, 12'h222, 32'h0000_2020, 32'h20, 5'd4, 5'd6, 5'd8);
        apply(i, exp_data(i, 1, 0));
        for (int k = 1; k <= 3; k++) begin
            i = mk_in(0, 1, 0, 1, 12'h333, 32'h0000_3000 + 32'(k), 32'h20 + 32'(4 * k),
                      5'd12, 5'd13, 5'd14);
            apply(i, last_exp);
        end
        i = mk_in(0, 0, 0, 1, 12'h444, 32'h0000_3030, 32'h30, 5'd15, 5'd16, 5'd17);
        apply(i, exp_data(i, 1, 0));

        // Flush beats stall
        i = mk_in(0, 1, 1, 1, 12'h555, 32'h7777_7777, 32'h34, 5'd18, 5'd19, 5'd7);
        apply(i, exp_zero(1));
        i = mk_in(0, 1, 0, 1, 12'h666, 32'h8888_8888, 32'h38, 5'd1, 5'd1, 5'd1);
        apply(i, last_exp);

        // Invalid load keeps data but clears control and indices
        i = mk_in(0, 0, 0, 0, 12'hFFF, 32'h0000_00AA, 32'h3C, 5'd21, 5'd22, 5'd3);
        apply(i, exp_data(i, 0, 2));
        i = mk_in(0, 1, 0, 1, 12'h123, 32'h9999_9999, 32'h40, 5'd2, 5'd2, 5'd2);
        apply(i, last_exp);
        i = mk_in(0, 0, 0, 1, 12'h124, 32'hAAAA_5555, 32'h44, 5'd23, 5'd24, 5'd25);
        apply(i, exp_data(i, 1, 2));

        // Twenty flushes drive the counter into saturation
        for (int k = 0; k < 20; k++) begin
            c = (k + 3 > 15) ? 15 : k + 3;
            i = mk_in(0, 1'(k % 2), 1, 1, 12'h0AB, 32'h0000_0500 + 32'(k), 32'h100 + 32'(k),
                      5'd5, 5'd6, 5'd7);
            apply(i, exp_zero(NW'(c)));
        end
        i = mk_in(0, 0, 0, 0, 12'hABC, 32'h0BAD_0BAD, 32'h200, 5'd8, 5'd9, 5'd10);
        apply(i, exp_data(i, 0, 15));

        // Reset wins over simultaneous stall and flush
        i = mk_in(1, 1, 1, 1, 12'hDEF, 32'h1357_9BDF, 32'h300, 5'd11, 5'd12, 5'd13);
        apply(i, exp_zero(0));
        i = mk_in(0, 0, 0, 1, 12'h789, 32'h2468_ACE0, 32'h50, 5'd26, 5'd27, 5'd28);
        apply(i, exp_data(i, 1, 0));

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_execute_stage_reg.md
Name: decode_execute_stage_reg

Overview:
Parametrised Decode→Execute pipeline register for the pipelined RISC-V core. It adds:
- a valid bit;
- a packed control bundle;
- a stall (hold) input;
- prioritised synchronous reset, flush and stall;
- a saturating bubble counter for the hazard unit and performance counters.

Rs1/Rs2/Rd are cleared on flush and on invalid loads, so the forwarding and hazard logic never matches a bubble.

Parameters:
DATA_WIDTH, 32, width of register-file operands and immediate
ADDR_WIDTH, 32, width of PC and PC+4
REG_ADDR_WIDTH, 5, width of Rs1/Rs2/Rd register indices
CTRL_WIDTH, 12, width of packed control bundle (RegWrite, MemWrite, ALUControl, ALUSrc, ResultSrc, Branch, Jump)
CNT_WIDTH, 16, width of bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stallE  in  1  hold all E-side state this cycle
flushE  in  1  insert bubble this cycle
validD  in  1  D-stage holds a real instruction
ctrlD  in  CTRL_WIDTH  decoded control bundle
rd1D  in  DATA_WIDTH  register-file read data 1
rd2D  in  DATA_WIDTH  register-file read data 2
PCD  in  ADDR_WIDTH  PC of D-stage instruction
PCPlus4D  in  ADDR_WIDTH  PC+4 of D-stage instruction
ImmExtD  in  DATA_WIDTH  sign-extended immediate
Rs1D  in  REG_ADDR_WIDTH  source register 1 index
Rs2D  in  REG_ADDR_WIDTH  source register 2 index
RdD  in  REG_ADDR_WIDTH  destination register index
validE  out  1  E-stage holds a real instruction
ctrlE  out  CTRL_WIDTH  registered control bundle
rd1E  out  DATA_WIDTH  registered rd1
rd2E  out  DATA_WIDTH  registered rd2
PCE  out  ADDR_WIDTH  registered PC
PCPlus4E  out  ADDR_WIDTH  registered PC+4
ImmExtE  out  DATA_WIDTH  registered immediate
Rs1E  out  REG_ADDR_WIDTH  registered Rs1
Rs2E  out  REG_ADDR_WIDTH  registered Rs2
RdE  out  REG_ADDR_WIDTH  registered Rd
bubble_count  out  CNT_WIDTH  number of edges on which a bubble entered E, saturating

Behaviour:
- Single register stage; latency is 1 cycle from D inputs to E outputs. No combinational path from inputs to outputs.
- Per-edge priority: rst > flushE > stallE > load.
- rst=1: every output is 0, including validE, ctrlE, all data, PCs, indices and bubble_count.
- flushE=1 (rst=0), regardless of stallE:
  - validE, ctrlE, rd1E, rd2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE ← 0.
  - bubble_count increments.
- stallE=1 (rst=0, flushE=0): all E outputs and bubble_count hold their values.
- Load (rst=0, flushE=0, stallE=0):
  - validD=1: all E outputs ← corresponding D inputs; validE ← 1.
  - validD=0: validE ← 0; ctrlE, Rs1E, Rs2E, RdE ← 0; data and PC fields still captured; bubble_count increments.
- Bubble counter:
  - +1 exactly on the edges where validE is written to 0 by a flush or an invalid load.
  - Saturates at 2^CNT_WIDTH−1 and never wraps. Cleared only by rst.
- Data/address fields may differ in width (ADDR_WIDTH ≠ DATA_WIDTH); there is no truncation or extension inside the block.
- Reset mid-stall or mid-flush: reset wins and the state is fully zeroed on that edge.
- The next non-stalled edge after stall release loads the then-current D inputs; nothing captured during the stall is replayed.

Test Plan:
- Reset: apply stimulus with non-zero D inputs and rst=1 for 2 cycles → all outputs 0, bubble_count=0. The first edge after rst drops with validD=1, rd1D=0x12345678, RdD=5 → rd1E=0x12345678, RdE=5, validE=1.
- Pass-through: 4 consecutive valid instructions with PCD=0x0,0x4,0x8,0xC → PCE follows each one a cycle later, PCPlus4E=PCE+4, validE=1 throughout, bubble_count=0.
- Stall: load PCD=0x20, then stallE=1 for 3 cycles while PCD changes to 0x24/0x28/0x2C → PCE stays 0x20 and bubble_count is unchanged. Release with PCD=0x30 → PCE=0x30.
- Flush vs stall: stallE=1 and flushE=1 on the same edge with RdD=7 → validE=0, RdE=0, ctrlE=0, all data fields 0, bubble_count+1.
- Invalid load: validD=0, rd1D=0xAA, RdD=3, ctrlD=0xFFF → validE=0, RdE=0, ctrlE=0, rd1E=0xAA, bubble_count+1.
- Saturation (CNT_WIDTH=4): 20 consecutive flushes → bubble_count reaches 15 and holds at 15. rst → 0.
